// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer on the core data bus: prescaled counter, latched
// compare-match flag, active-low interrupt and registered (two-cycle) read data.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic [1:0]  data_bus_reqw,
    input  logic        data_bus_reqs,
    output logic        irq_n
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 8;

    localparam logic [1:0] MODE_READ   = 2'b01;
    localparam logic [1:0] MODE_WRITE  = 2'b10;
    localparam logic [1:0] REQW_BYTE   = 2'b00;
    localparam logic [1:0] REQW_HALF   = 2'b01;
    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    logic          en_q, en_d;
    logic          ar_q, ar_d;
    logic          irqen_q, irqen_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] compare_q, compare_d;
    logic          match_q, match_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          irq_n_q, irq_n_d;

    logic          hit_c, rd_hit_c, wr_hit_c, aligned_c;
    logic [1:0]    off_c, lane_c;
    logic [3:0]    be_c;
    logic [DW-1:0] wdat_c, wmask_c;
    logic [DW-1:0] ctrl_word_c, sel_c, shifted_c, rd_val_c, wr_merge_c;
    logic          tick_c, cmp_eq_c;

    // Address decode, byte enables and lane-replicated write data
    always_comb begin
        hit_c     = (data_bus_addr[DW-1:4] == BASE_ADDR[DW-1:4]);
        off_c     = data_bus_addr[3:2];
        lane_c    = data_bus_addr[1:0];
        aligned_c = 1'b1;
        be_c      = 4'b1111;
        wdat_c    = data_bus_data;
        case (data_bus_reqw)
            REQW_BYTE: begin
                be_c   = 4'b0001 << lane_c;
                wdat_c = {4{data_bus_data[7:0]}};
            end
            REQW_HALF: begin
                aligned_c = ~lane_c[0];
                be_c      = lane_c[1] ? 4'b1100 : 4'b0011;
                wdat_c    = {2{data_bus_data[15:0]}};
            end
            default: aligned_c = (lane_c == 2'b00);
        endcase
        rd_hit_c = hit_c && (data_bus_mode == MODE_READ);
        wr_hit_c = hit_c && (data_bus_mode == MODE_WRITE) && aligned_c;
        wmask_c  = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
    end

    // Register select, read alignment/extension and write merge
    always_comb begin
        ctrl_word_c = {16'h0000, presc_q, 5'b00000, irqen_q, ar_q, en_q};
        case (off_c)
            OFF_CTRL:    sel_c = ctrl_word_c;
            OFF_COUNT:   sel_c = count_q;
            OFF_COMPARE: sel_c = compare_q;
            default:     sel_c = {31'd0, match_q};
        endcase
        shifted_c = sel_c >> {lane_c, 3'b000};
        case (data_bus_reqw)
            REQW_BYTE: rd_val_c = {{24{data_bus_reqs & shifted_c[7]}}, shifted_c[7:0]};
            REQW_HALF: rd_val_c = {{16{data_bus_reqs & shifted_c[15]}}, shifted_c[15:0]};
            default:   rd_val_c = shifted_c;
        endcase
        if (!aligned_c) begin
            rd_val_c = '0;
        end
        wr_merge_c = (sel_c & ~wmask_c) | (wdat_c & wmask_c);
    end

    // Next state: tick update first, bus writes override, match set wins last
    always_comb begin
        en_d      = en_q;
        ar_d      = ar_q;
        irqen_d   = irqen_q;
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        rdata_d   = rd_hit_c ? rd_val_c : rdata_q;

        tick_c   = en_q && (psc_q == presc_q);
        cmp_eq_c = (count_q == compare_q);
        psc_d    = (!en_q || tick_c) ? '0 : psc_q + PW'(1);

        if (tick_c) begin
            if (cmp_eq_c) begin
                if (ar_q) begin
                    count_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + DW'(1);
            end
        end

        if (wr_hit_c) begin
            case (off_c)
                OFF_CTRL: begin
                    en_d    = wr_merge_c[0];
                    ar_d    = wr_merge_c[1];
                    irqen_d = wr_merge_c[2];
                    presc_d = wr_merge_c[15:8];
                    if (be_c[1]) begin
                        psc_d = '0;
                    end
                end
                OFF_COUNT:   count_d   = wr_merge_c;
                OFF_COMPARE: compare_d = wr_merge_c;
                default: begin
                    if (be_c[0] && wdat_c[0]) begin
                        match_d = 1'b0;
                    end
                end
            endcase
        end

        if (tick_c && cmp_eq_c) begin
            match_d = 1'b1;
        end
        if (!en_d) begin
            psc_d = '0;
        end
        irq_n_d = ~(match_d & irqen_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            irqen_q   <= 1'b0;
            presc_q   <= '0;
            psc_q     <= '0;
            count_q   <= '0;
            compare_q <= '1;
            match_q   <= 1'b0;
            rdata_q   <= '0;
            irq_n_q   <= 1'b1;
        end else begin
            en_q      <= en_d;
            ar_q      <= ar_d;
            irqen_q   <= irqen_d;
            presc_q   <= presc_d;
            psc_q     <= psc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            rdata_q   <= rdata_d;
            irq_n_q   <= irq_n_d;
        end
    end

    // Bus is released during reset and on anything but a read hit
    assign data_bus_data = (rd_hit_c && reset) ? rdata_q : {DW{1'bz}};
    assign irq_n         = irq_n_q;

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed vector table, timer corner sequences and
// randomized bus traffic checked against a cycle-level register model.
`timescale 1ns/1ps
module tb_bus_timer;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [1:0]  M_IDLE = 2'b00;
    localparam logic [1:0]  M_RD   = 2'b01;
    localparam logic [1:0]  M_WR   = 2'b10;
    localparam logic [1:0]  M_RSV  = 2'b11;
    localparam logic [1:0]  W_B    = 2'b00;
    localparam logic [1:0]  W_H    = 2'b01;
    localparam logic [1:0]  W_W    = 2'b10;
    localparam logic [1:0]  W_RSV  = 2'b11;
    localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [1:0]  mode;
    logic [1:0]  reqw;
    logic        reqs;
    logic        tb_drv;
    logic [31:0] tb_wd;
    wire  [31:0] bus;
    logic        irq_n;

    int errors;
    int checks;

    // Undriven bus floats to all ones through the pullup
    assign bus = tb_drv ? tb_wd : 32'hzzzz_zzzz;
    pullup pu_bus (bus);

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_bus_data (bus),
        .data_bus_addr (addr),
        .data_bus_mode (mode),
        .data_bus_reqw (reqw),
        .data_bus_reqs (reqs),
        .irq_n         (irq_n)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic        m_en, m_ar, m_irqen, m_match, m_irq_n;
    logic [7:0]  m_presc;
    int          m_psc;
    logic [31:0] m_count, m_compare, m_rdata;

    function automatic logic is_hit(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic [1:0] md, input logic [31:0] a,
                              input logic [1:0] w, input logic s, input logic [31:0] wd);
        logic [31:0] regs [4];
        logic [31:0] img, new_count, new_compare;
        logic        new_en, new_ar, new_irqen, new_match, set, psc_clr, tick;
        logic [7:0]  new_presc;
        int          off, lane, nb, new_psc;
        bit          aligned;
        if (!rst_n) begin
            m_en = 0; m_ar = 0; m_irqen = 0; m_presc = 0; m_psc = 0;
            m_count = 0; m_compare = ONES; m_match = 0; m_rdata = 0; m_irq_n = 1;
            return;
        end
        off     = int'(a[3:2]);
        lane    = int'(a[1:0]);
        nb      = (w == W_B) ? 1 : (w == W_H) ? 2 : 4;
        aligned = (lane % nb) == 0;
        regs[0] = {16'h0, m_presc, 5'h0, m_irqen, m_ar, m_en};
        regs[1] = m_count;
        regs[2] = m_compare;
        regs[3] = {31'h0, m_match};

        if (md == M_RD && is_hit(a)) begin
            if (!aligned) m_rdata = 0;
            else begin
                img = regs[off] >> (8 * lane);
                if (nb == 1)      m_rdata = (s && img[7])  ? (img | 32'hFFFF_FF00) : (img & 32'h0000_00FF);
                else if (nb == 2) m_rdata = (s && img[15]) ? (img | 32'hFFFF_0000) : (img & 32'h0000_FFFF);
                else              m_rdata = img;
            end
        end

        tick = m_en && (m_psc == int'(m_presc));
        new_count = m_count; new_compare = m_compare; new_en = m_en; new_ar = m_ar;
        new_irqen = m_irqen; new_presc = m_presc; new_match = m_match; set = 0; psc_clr = 0;
        new_psc = (m_en && !tick) ? m_psc + 1 : 0;
        if (tick) begin
            if (m_count == m_compare) begin
                set = 1;
                if (m_ar) new_count = 0;
                else      new_en = 0;
            end else begin
                new_count = m_count + 1;
            end
        end

        if (md == M_WR && is_hit(a) && aligned) begin
            img = regs[off];
            for (int b = 0; b < nb; b++) img[8*(lane+b) +: 8] = wd[8*b +: 8];
            case (off)
                0: begin
                    new_en = img[0]; new_ar = img[1]; new_irqen = img[2]; new_presc = img[15:8];
                    psc_clr = (lane <= 1) && (lane + nb > 1);
                end
                1: new_count = img;
                2: new_compare = img;
                default: if (lane == 0 && wd[0]) new_match = 0;
            endcase
        end
        if (set) new_match = 1;
        if (!new_en || psc_clr) new_psc = 0;

        m_en = new_en; m_ar = new_ar; m_irqen = new_irqen; m_presc = new_presc; m_psc = new_psc;
        m_count = new_count; m_compare = new_compare; m_match = new_match;
        m_irq_n = !(new_match && new_irqen);
    endtask

    // One bus cycle: drive, clock, update model, sample on the falling edge
    task automatic step(input logic rst_n, input logic [1:0] md, input logic [31:0] a,
                        input logic [1:0] w, input logic s, input logic [31:0] wd);
        reset  = rst_n;
        mode   = md;
        addr   = a;
        reqw   = w;
        reqs   = s;
        tb_drv = (md == M_WR);
        tb_wd  = wd;
        @(posedge clk);
        model_edge(rst_n, md, a, w, s, wd);
        @(negedge clk);
        chk("model_irq_n", {31'h0, irq_n}, {31'h0, m_irq_n});
        if (rst_n && md == M_RD && is_hit(a))
            chk("model_rdata", bus, m_rdata);
        else if (md != M_WR && m_rdata != ONES)
            chk("bus_release", bus, ONES);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] w, input logic s,
                      input logic [31:0] exp_bus, input logic exp_irq, input string nm);
        step(1'b1, M_RD, a, w, s, 32'h0);
        chk({nm, "_data"}, bus, exp_bus);
        chk({nm, "_irq"}, {31'h0, irq_n}, {31'h0, exp_irq});
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd);
        step(1'b1, M_WR, a, w, 1'b0, wd);
    endtask

    typedef struct {
        logic [1:0]  md;
        logic [31:0] a;
        logic [1:0]  w;
        logic        s;
        logic [31:0] wd;
        logic        chk_bus;
        logic [31:0] exp_bus;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [1:0] md, input logic [31:0] a, input logic [1:0] w,
                        input logic s, input logic [31:0] wd, input logic cb, input logic [31:0] eb);
        vec_t v;
        v.md = md; v.a = a; v.w = w; v.s = s; v.wd = wd; v.chk_bus = cb; v.exp_bus = eb; v.exp_irq = 1'b1;
        vecs.push_back(v);
    endtask

    logic [1:0]  r_md, r_w;
    logic [31:0] r_a, r_wd;
    logic        r_s, r_rst;
    int          sel;

    initial begin
        errors = 0; checks = 0;
        clk = 0; reset = 0; mode = M_IDLE; addr = 0; reqw = W_W; reqs = 0; tb_drv = 0; tb_wd = 0;

        // Reset, including a read abandoned by reset
        step(1'b0, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        step(1'b0, M_RD, BASE + 4, W_W, 1'b0, 32'h0);
        chk("reset_irq_n", {31'h0, irq_n}, 32'h1);

        addv(M_RD,   BASE + 32'h0, W_W,   0, 0, 1, 32'h0000_0000);
        addv(M_RD,   BASE + 32'h4, W_W,   0, 0, 1, 32'h0000_0000);
        addv(M_RD,   BASE + 32'h8, W_W,   0, 0, 1, 32'hFFFF_FFFF);
        addv(M_RD,   BASE + 32'hC, W_W,   0, 0, 1, 32'h0000_0000);
        addv(M_IDLE, BASE + 32'h0, W_W,   0, 0, 1, ONES);
        addv(M_WR,   BASE + 32'h5, W_B,   0, 32'h0000_0080, 0, 0);
        addv(M_RD,   BASE + 32'h5, W_B,   1, 0, 1, 32'hFFFF_FF80);
        addv(M_RD,   BASE + 32'h5, W_B,   0, 0, 1, 32'h0000_0080);
        addv(M_RD,   BASE + 32'h4, W_H,   1, 0, 1, 32'hFFFF_8000);
        addv(M_RD,   BASE + 32'h4, W_H,   0, 0, 1, 32'h0000_8000);
        addv(M_WR,   BASE + 32'h9, W_H,   0, 32'h0000_1234, 0, 0);
        addv(M_RD,   BASE + 32'h8, W_W,   0, 0, 1, 32'hFFFF_FFFF);
        addv(M_WR,   BASE + 32'hA, W_H,   0, 32'h0000_0000, 0, 0);
        addv(M_RD,   BASE + 32'h8, W_W,   0, 0, 1, 32'h0000_FFFF);
        addv(M_RD,   BASE + 32'h8, W_H,   1, 0, 1, 32'hFFFF_FFFF);
        addv(M_RD,   BASE + 32'hB, W_B,   1, 0, 1, 32'h0000_0000);
        addv(M_WR,   BASE + 32'h10, W_W,  0, 32'h0000_0005, 0, 0);
        addv(M_RD,   BASE + 32'h10, W_W,  0, 0, 1, ONES);
        addv(M_RD,   BASE + 32'h0, W_W,   0, 0, 1, 32'h0000_0000);
        addv(M_RSV,  BASE + 32'h4, W_W,   0, 0, 1, ONES);
        addv(M_RD,   BASE + 32'h4, W_RSV, 0, 0, 1, 32'h0000_8000);
        addv(M_RD,   BASE + 32'h6, W_W,   0, 0, 1, 32'h0000_0000);
        addv(M_RD,   BASE + 32'h5, W_H,   1, 0, 1, 32'h0000_0000);

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].md, vecs[i].a, vecs[i].w, vecs[i].s, vecs[i].wd);
            if (vecs[i].chk_bus) chk($sformatf("vec%0d_bus", i), bus, vecs[i].exp_bus);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq_n}, {31'h0, vecs[i].exp_irq});
        end

        // Auto-reload with PRESC=0: COUNT 0,1,2,3,0 and interrupt on match
        step(1'b0, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        wr(BASE + 32'h8, W_W, 32'd3);
        wr(BASE + 32'h0, W_W, 32'h0000_0007);
        rd(BASE + 32'h4, W_W, 0, 32'd0, 1'b1, "ar_cnt0");
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b1, "ar_cnt1");
        rd(BASE + 32'h4, W_W, 0, 32'd2, 1'b1, "ar_cnt2");
        rd(BASE + 32'h4, W_W, 0, 32'd3, 1'b0, "ar_cnt3");
        rd(BASE + 32'h4, W_W, 0, 32'd0, 1'b0, "ar_wrap");
        rd(BASE + 32'hC, W_W, 0, 32'd1, 1'b0, "ar_status");
        wr(BASE + 32'hC, W_W, 32'd1);
        chk("ar_clear_irq", {31'h0, irq_n}, 32'h1);
        step(1'b1, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        chk("ar_rematch_irq", {31'h0, irq_n}, 32'h0);
        wr(BASE + 32'h0, W_W, 32'h0);
        chk("ar_irqen_off", {31'h0, irq_n}, 32'h1);
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b1, "ar_stopped");

        // One-shot with PRESC=2: tick every third cycle, EN cleared on match
        step(1'b0, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        wr(BASE + 32'h8, W_W, 32'd1);
        wr(BASE + 32'h0, W_W, 32'h0000_0205);
        rd(BASE + 32'h4, W_W, 0, 32'd0, 1'b1, "os_c1");
        rd(BASE + 32'h4, W_W, 0, 32'd0, 1'b1, "os_c2");
        rd(BASE + 32'h4, W_W, 0, 32'd0, 1'b1, "os_c3");
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b1, "os_c4");
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b1, "os_c5");
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b0, "os_c6");
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b0, "os_c7");
        rd(BASE + 32'h4, W_W, 0, 32'd1, 1'b0, "os_c8");
        rd(BASE + 32'h0, W_W, 0, 32'h0000_0204, 1'b0, "os_ctrl");
        rd(BASE + 32'hC, W_W, 0, 32'd1, 1'b0, "os_status");
        wr(BASE + 32'h0, W_B, 32'h0);
        chk("os_irqen_off", {31'h0, irq_n}, 32'h1);

        // Clear loses to a same-cycle match; COUNT write beats the tick
        step(1'b0, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        wr(BASE + 32'h8, W_W, 32'd2);
        wr(BASE + 32'h0, W_W, 32'h0000_0003);
        step(1'b1, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        step(1'b1, M_IDLE, BASE, W_W, 1'b0, 32'h0);
        wr(BASE + 32'hC, W_W, 32'd1);
        rd(BASE + 32'hC, W_W, 0, 32'd1, 1'b1, "sim_match_wins");
        wr(BASE + 32'h4, W_W, 32'h0000_0100);
        rd(BASE + 32'h4, W_W, 0, 32'h0000_0100, 1'b1, "sim_count_wins");

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 99) != 0);
            r_md  = 2'($urandom_range(0, 3));
            r_w   = 2'($urandom_range(0, 3));
            r_s   = 1'($urandom_range(0, 1));
            r_wd  = $urandom;
            sel   = $urandom_range(0, 19);
            if (sel < 17)      r_a = BASE + 32'($urandom_range(0, 15));
            else if (sel < 19) r_a = BASE + 32'($urandom_range(16, 255));
            else               r_a = $urandom;
            if (r_md == M_WR && is_hit(r_a)) begin
                case (r_a[3:2])
                    2'd0: begin
                        r_wd[15:8] = 8'($urandom_range(0, 3));
                        if (r_a[1:0] == 2'd1) r_wd[7:0] = 8'($urandom_range(0, 3));
                        if ($urandom_range(0, 3) != 0) r_wd[0] = 1'b1;
                    end
                    2'd1, 2'd2: if ($urandom_range(0, 1) == 1) r_wd = 32'($urandom_range(0, 12));
                    default: ;
                endcase
            end
            step(r_rst, r_md, r_a, r_w, r_s, r_wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 32-bit timer peripheral that responds on the core's data bus.
- Decodes core-issued read and write requests in a 16-byte window and serves byte, half and word widths, with optional sign extension on reads.
- Counts prescaled clock ticks, latches a compare-match flag, and drives one active-low interrupt line into the core's irq_sources.
- Read data is registered so that it meets the core's two-cycle stalled-load timing.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base address of the 16-byte register window.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_bus_data  inout  32  driven by this block only during a read hit, high-Z otherwise.
- data_bus_addr  input  32  byte address.
- data_bus_mode  input  2  00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- data_bus_reqw  input  2  access width: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- data_bus_reqs  input  1  1 sign-extends byte/half reads, 0 zero-extends them.
- irq_n  output  1  active-low interrupt to the core.

Behaviour:
- Hit: data_bus_addr[31:4] == BASE_ADDR[31:4]. Register offset is addr[3:2]; byte lane is addr[1:0].
- Registers:
  - 0x0 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, bits[15:8] PRESC. Other bits read 0 and ignore writes.
  - 0x4 COUNT: 32-bit counter, read/write.
  - 0x8 COMPARE: 32-bit, read/write.
  - 0xC STATUS: bit0 MATCH. Writing 1 to bit0 clears it; writing 0 has no effect. Other bits read 0.
- Reset, with reset low at a clk edge: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, prescaler counter=0, read register=0, irq_n=1, bus released. Reset asserted mid-access abandons the access; reset has priority over every other event.
- Writes (mode==10 and hit) take effect at the rising edge.
  - Byte write updates lane addr[1:0] with data[7:0].
  - Half write updates lanes {addr[1],0} and {addr[1],1} with data[15:0].
  - Word write updates the whole register with data[31:0].
  - Misaligned half (addr[0]=1) or word (addr[1:0]!=0) writes are ignored.
- Reads (mode==01 and hit):
  - At every rising edge the read register captures the selected register value, lane-shifted so the addressed byte/half sits at bits[7:0]/[15:0], then zero- or sign-extended per reqs. A misaligned read captures 0.
  - data_bus_data is driven from the read register combinationally while mode==01 and hit. Valid data is therefore present from the second cycle of a read, matching the core's two-cycle load stall.
  - The first-cycle value on the bus is don't-care.
- Prescaler: while EN=1, the prescaler counter increments each cycle. When it equals PRESC, it resets to 0 and a tick is generated.
  - PRESC=0 gives a tick every cycle.
  - With EN=0 the prescaler counter holds at 0.
- Tick:
  - If COUNT==COMPARE: MATCH<=1. Then if AUTORELOAD=1, COUNT<=0; otherwise COUNT holds and EN<=0 (one-shot).
  - Else COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - A bus write to COUNT or CTRL in a tick cycle wins over the tick update; MATCH is still set if that tick matched.
  - A write-1-clear of MATCH in a match cycle leaves MATCH=1 (set wins).
  - A write to CTRL.PRESC resets the prescaler counter to 0.
- irq_n is registered: irq_n <= ~(MATCH_next & IRQEN_next). It asserts one cycle after the tick edge and deasserts one cycle after the clear. It stays low until MATCH is cleared or IRQEN is written 0.
- Misses, idle and reserved modes: no register changes from the bus; data_bus_data is high-Z.

Test Plan:
- Reset, then word reads of 0x1000/0x1004/0x1008/0x100C -> second-cycle values 0, 0, 0xFFFF_FFFF, 0; irq_n=1; bus high-Z when mode=00.
- Write COMPARE=3, CTRL=0x7 (EN, AUTORELOAD, IRQEN, PRESC=0) -> COUNT sequence 0,1,2,3,0. MATCH=1 at the 3->0 tick; irq_n low the following cycle. Writing 1 to STATUS sets irq_n high one cycle later.
- CTRL=0x0205 (one-shot, PRESC=2), COMPARE=1 -> COUNT increments every 3 cycles. After the match, COUNT holds at 1, CTRL.EN reads 0, MATCH=1.
- Write 0x80 to byte 0x1005, then read byte 0x1005 with reqs=1 -> 0xFFFF_FF80. With reqs=0 -> 0x0000_0080. Half read at 0x1004 with reqs=1 -> 0xFFFF_8000.
- Misaligned half write to 0x1009 -> COMPARE unchanged. Access to 0x1010 -> bus high-Z, no register changes.
- Write-1-clear of STATUS in the same cycle as a match -> MATCH stays 1. A COUNT write in a tick cycle -> the written value wins.
